snoop_bus_arbiter: RTL

Shared-bus arbiter and snoop router for the dual-core MSI system. It sits between the two processor cores. It grants bus ownership round-robin from each core's `req_core`. During a tenure it forwards the owner's bus transaction (address, data, operation) to the other core's snoop inputs, and returns the snooper's `cache_hit_out`, `flush_out` and flushed data to the owner. It also flags tenures that exceed a cycle budget.

---
 rtl/snoop_bus_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/snoop_bus_arbiter.sv
// Round-robin bus arbiter for two MSI cores: grants ownership, routes the owner's
// transaction to the other core's snoop port and returns hit/flush data to the owner.
module snoop_bus_arbiter #(
    parameter int MAX_TENURE = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_core_0,
    input  logic        req_core_1,
    output logic        grant_0,
    output logic        grant_1,
    input  logic [31:0] bus_data_out_0,
    input  logic [31:0] bus_data_out_1,
    input  logic [31:0] bus_address_out_0,
    input  logic [31:0] bus_address_out_1,
    input  logic [1:0]  bus_operation_out_0,
    input  logic [1:0]  bus_operation_out_1,
    input  logic        cache_hit_out_0,
    input  logic        cache_hit_out_1,
    input  logic        flush_out_0,
    input  logic        flush_out_1,
    output logic [31:0] bus_data_in_0,
    output logic [31:0] bus_data_in_1,
    output logic [31:0] bus_address_in_0,
    output logic [31:0] bus_address_in_1,
    output logic [1:0]  bus_operation_in_0,
    output logic [1:0]  bus_operation_in_1,
    output logic        cache_hit_in_0,
    output logic        cache_hit_in_1,
    output logic        owner,
    output logic        bus_busy,
    output logic        tenure_error
);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    localparam logic [1:0] OP_NONE = 2'b11;
    localparam logic [7:0] MAX_CNT = 8'(MAX_TENURE);

    state_t      state, state_next;
    logic        last_owner, last_owner_next;
    logic        owner_next, owner_req;
    logic [7:0]  count, count_next;
    logic        tenure_error_next, bus_busy_next;
    logic        grant_0_next, grant_1_next;
    logic [31:0] data_in_0_next, data_in_1_next;
    logic [31:0] address_in_0_next, address_in_1_next;
    logic [1:0]  operation_in_0_next, operation_in_1_next;
    logic        hit_in_0_next, hit_in_1_next;

    assign owner_req = owner ? req_core_1 : req_core_0;

    always_comb begin
        state_next        = state;
        owner_next        = owner;
        last_owner_next   = last_owner;
        count_next        = count;
        tenure_error_next = tenure_error;
        case (state)
            IDLE: begin
                // On a tie the core that did not own the bus last time wins
                if (req_core_0 && (!req_core_1 || last_owner)) begin
                    owner_next = 1'b0;
                end else if (req_core_1) begin
                    owner_next = 1'b1;
                end
                if (req_core_0 || req_core_1) begin
                    state_next      = OWN;
                    last_owner_next = owner_next;
                    count_next      = 8'd1;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    state_next = TURN;
                    count_next = '0;
                end else begin
                    if (count != MAX_CNT) count_next = count + 8'd1;
                    if (count_next == MAX_CNT) tenure_error_next = 1'b1;
                end
            end
            TURN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_0_next        = (state_next == OWN) && !owner_next;
        grant_1_next        = (state_next == OWN) && owner_next;
        bus_busy_next       = (state_next != IDLE);
        data_in_0_next      = '0;
        data_in_1_next      = '0;
        address_in_0_next   = '0;
        address_in_1_next   = '0;
        operation_in_0_next = OP_NONE;
        operation_in_1_next = OP_NONE;
        hit_in_0_next       = 1'b0;
        hit_in_1_next       = 1'b0;
        // Routing only while a tenure continues; grant and release edges show idle values
        if (state == OWN && state_next == OWN) begin
            if (!owner) begin
                address_in_1_next   = bus_address_out_0;
                operation_in_1_next = bus_operation_out_0;
                data_in_1_next      = bus_data_out_0;
                hit_in_0_next       = cache_hit_out_1;
                data_in_0_next      = flush_out_1 ? bus_data_out_1 : '0;
            end else begin
                address_in_0_next   = bus_address_out_1;
                operation_in_0_next = bus_operation_out_1;
                data_in_0_next      = bus_data_out_1;
                hit_in_1_next       = cache_hit_out_0;
                data_in_1_next      = flush_out_0 ? bus_data_out_0 : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            owner              <= 1'b0;
            last_owner         <= 1'b1;
            count              <= '0;
            tenure_error       <= 1'b0;
            bus_busy           <= 1'b0;
            grant_0            <= 1'b0;
            grant_1            <= 1'b0;
            bus_data_in_0      <= '0;
            bus_data_in_1      <= '0;
            bus_address_in_0   <= '0;
            bus_address_in_1   <= '0;
            bus_operation_in_0 <= OP_NONE;
            bus_operation_in_1 <= OP_NONE;
            cache_hit_in_0     <= 1'b0;
            cache_hit_in_1     <= 1'b0;
        end else begin
            state              <= state_next;
            owner              <= owner_next;
            last_owner         <= last_owner_next;
            count              <= count_next;
            tenure_error       <= tenure_error_next;
            bus_busy           <= bus_busy_next;
            grant_0            <= grant_0_next;
            grant_1            <= grant_1_next;
            bus_data_in_0      <= data_in_0_next;
            bus_data_in_1      <= data_in_1_next;
            bus_address_in_0   <= address_in_0_next;
            bus_address_in_1   <= address_in_1_next;
            bus_operation_in_0 <= operation_in_0_next;
            bus_operation_in_1 <= operation_in_1_next;
            cache_hit_in_0     <= hit_in_0_next;
            cache_hit_in_1     <= hit_in_1_next;
        end
    end

endmodule
